// File: rtl/cic_pkg.sv
// ============================================================================
// Module      : cic_pkg
// Description : Shared CIC decimator constants used by the integrator,
//               decimation and comb blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cic_pkg;

  localparam int CIC_W     = 21;  // integrator / decimator / comb data width
  localparam int CIC_R     = 5;   // decimation ratio
  localparam int CIC_N     = 3;   // number of comb stages
  localparam int CIC_M     = 1;   // differential delay in samples
  localparam int CIC_OUT_W = 16;  // width handed to the downstream consumer

endpackage : cic_pkg

`default_nettype wire

// File: rtl/cic_comb_stage.sv
// ============================================================================
// Module      : cic_comb_stage
// Description : One comb differentiator y[n] = x[n] - x[n-M], with the delay
//               counted in accepted samples. Wraps modulo 2^W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = CIC_W,
  parameter int M = CIC_M
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic [W-1:0] hist_q [M];
  logic [W-1:0] hist_d [M];

  always_comb begin
    data_d    = data_i - hist_q[M-1];
    hist_d[0] = data_i;
    for (int i = 1; i < M; i++) begin
      hist_d[i] = hist_q[i-1];
    end
  end

  // History only advances on accepted samples, so the delay is in samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < M; i++) begin
        hist_q[i] <= '0;
      end
    end else if (en) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_d;
        hist_q <= hist_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : cic_comb_stage

`default_nettype wire

// File: rtl/cic_comb.sv
// ============================================================================
// Module      : cic_comb
// Description : CIC comb section: N cascaded differentiators followed by a
//               registered output scaler (truncation, or rounding with
//               saturation when CIC_COMB_ROUND_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_comb
  import cic_pkg::*;
#(
  parameter int W     = CIC_W,
  parameter int N     = CIC_N,
  parameter int M     = CIC_M,
  parameter int OUT_W = CIC_OUT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             valid_in,
  input  logic [W-1:0]     din,
  output logic             valid_out,
  output logic [OUT_W-1:0] dout
);

  logic [N:0]          stage_valid;
  logic [N:0][W-1:0]   stage_data;
  logic [W-1:0]        final_data;
  logic [OUT_W-1:0]    dout_d;
  logic [OUT_W-1:0]    dout_q;
  logic                valid_q;

  assign stage_valid[0] = valid_in;
  assign stage_data[0]  = din;

  generate
    for (genvar k = 0; k < N; k++) begin : g_stage
      cic_comb_stage #(
        .W (W),
        .M (M)
      ) u_stage (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .valid_i (stage_valid[k]),
        .data_i  (stage_data[k]),
        .valid_o (stage_valid[k+1]),
        .data_o  (stage_data[k+1])
      );
    end
  endgenerate

  assign final_data = stage_data[N];

`ifdef CIC_COMB_ROUND_EN
  generate
    if (OUT_W < W) begin : g_round
      localparam int          SH   = W - OUT_W;
      localparam logic [W:0]  HALF = {{W{1'b0}}, 1'b1} << (SH - 1);
      logic [W:0]        sum;
      logic signed [W:0] shifted;
      logic              in_range;

      // One extra bit keeps the +half from overflowing before the shift.
      assign sum      = {final_data[W-1], final_data} + HALF;
      assign shifted  = $signed(sum) >>> SH;
      assign in_range = (&shifted[W:OUT_W-1]) | ~(|shifted[W:OUT_W-1]);
      assign dout_d   = in_range ? shifted[OUT_W-1:0]
                      : (shifted[W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}});
    end else begin : g_pass
      assign dout_d = final_data[W-1 -: OUT_W];
    end
  endgenerate
`else
  generate
    if (OUT_W < W) begin : g_trunc
      logic unused_lsbs;
      assign unused_lsbs = ^final_data[W-OUT_W-1:0];
      assign dout_d      = final_data[W-1 -: OUT_W];
    end else begin : g_pass
      assign dout_d = final_data[W-1 -: OUT_W];
    end
  endgenerate
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else if (en) begin
      valid_q <= stage_valid[N];
      if (stage_valid[N]) begin
        dout_q <= dout_d;
      end
    end
  end

  // A held strobe must not be seen while frozen; it reappears when en returns.
  assign valid_out = valid_q & en;
  assign dout      = dout_q;

endmodule : cic_comb

`default_nettype wire

// File: tb/tb_cic_comb.sv
// ============================================================================
// Module      : tb_cic_comb
// Description : Scoreboard bench for cic_comb with directed vectors; expected
//               values follow the CIC_COMB_ROUND_EN build setting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cic_comb;

  localparam int W     = 21;
  localparam int N     = 3;
  localparam int OUT_W = 16;

  typedef struct {
    logic [OUT_W-1:0] val;
    int               cyc;
    string            name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b1;
  logic             valid_in = 1'b0;
  logic [W-1:0]     din = '0;
  logic             valid_out;
  logic [OUT_W-1:0] dout;

  exp_t q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  cic_comb #(.W(W), .N(N), .M(1), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .valid_in  (valid_in),
    .din       (din),
    .valid_out (valid_out),
    .dout      (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every visible strobe must match the oldest expectation.
  exp_t got;
  always @(negedge clk) begin
    if (valid_out) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: dout=%0d at cycle %0d, required no strobe",
                 $signed(dout), cyc);
      end else begin
        got = q.pop_front();
        if (dout !== got.val || cyc != got.cyc) begin
          n_err++;
          $display("FAIL %s: dout=%0d cycle=%0d, required dout=%0d cycle=%0d",
                   got.name, $signed(dout), cyc, $signed(got.val), got.cyc);
        end
      end
    end
  end

  task automatic tick(input logic v, input logic [W-1:0] d, input logic e);
    valid_in = v;
    din      = d;
    en       = e;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int v, input int c, input string nm);
    exp_t x;
    x.val  = OUT_W'(v);
    x.cyc  = c;
    x.name = nm;
    q.push_back(x);
  endtask

  // Decimator-style strobe: one valid, then four idle clocks.
  task automatic strobe(input int d, input int v, input string nm);
    tick(1'b1, W'(d), 1'b1);
    expect_out(v, cyc + N, nm);
    repeat (4) tick(1'b0, '0, 1'b1);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() > 0 && k < 40) begin
      tick(1'b0, '0, 1'b1);
      k++;
    end
    repeat (5) tick(1'b0, '0, 1'b1);
    check("drain_pending", 32'(q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    rstn     = 1'b0;
    q.delete();
    valid_in = 1'b0;
    din      = '0;
    en       = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick(1'b0, '0, 1'b1);
  endtask

  int rnd16 [4];
  int big   [4];
  int neg16 [4];
  int e0;

  initial begin
`ifdef CIC_COMB_ROUND_EN
    rnd16 = '{1, -1, 2, 0};
    big   = '{32767, -32766, 32767, -32767};
    neg16 = '{0, 2, -1, 1};
`else
    rnd16 = '{0, -2, 1, -1};
    big   = '{32767, -32767, 32766, -32768};
    neg16 = '{-1, 1, -2, 0};
`endif

    #2;
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    tick(1'b0, '0, 1'b1);

    // Impulse of 32: (1 - z^-1)^3 response scaled by 1/32
    strobe(32, 1, "imp0");
    strobe(0, -3, "imp1");
    strobe(0, 3, "imp2");
    strobe(0, -1, "imp3");
    strobe(0, 0, "imp4");
    strobe(0, 0, "imp5");
    drain();
    apply_reset();

    // Step of 32
    strobe(32, 1, "step0");
    strobe(32, -2, "step1");
    strobe(32, 1, "step2");
    strobe(32, 0, "step3");
    strobe(32, 0, "step4");
    drain();
    apply_reset();

    // Wrapping ramp: third difference of a line is zero from sample 3 on
    for (int n = 0; n < 12; n++) begin
      strobe(n * 'h3A000, (n == 1) ? 7424 : (n == 2) ? -7424 : 0, "ramp");
    end
    drain();
    apply_reset();

    // Back-to-back burst
    tick(1'b1, W'(32), 1'b1); expect_out(1, cyc + N, "b2b0");
    tick(1'b1, '0, 1'b1);     expect_out(-3, cyc + N, "b2b1");
    tick(1'b1, '0, 1'b1);     expect_out(3, cyc + N, "b2b2");
    tick(1'b1, '0, 1'b1);     expect_out(-1, cyc + N, "b2b3");
    drain();

    // Burst with en low for 2 clocks while an output is pending
    tick(1'b1, W'(32), 1'b1);
    e0 = cyc;
    expect_out(1, e0 + 3, "en0");
    tick(1'b1, '0, 1'b1); expect_out(-3, e0 + 6, "en1");
    tick(1'b1, '0, 1'b1); expect_out(3, e0 + 7, "en2");
    tick(1'b1, '0, 1'b1); expect_out(-1, e0 + 8, "en3");
    tick(1'b0, '0, 1'b1);
    en = 1'b0;
    #1;
    check("en_gate_valid0", 32'(valid_out), 32'd0);
    tick(1'b0, '0, 1'b0);
    check("en_gate_valid1", 32'(valid_out), 32'd0);
    tick(1'b0, '0, 1'b0);
    check("en_gate_valid2", 32'(valid_out), 32'd0);
    check("en_hold_dout", 32'(dout), 32'(16'hFFFD));
    drain();

    // Reset one clock after an impulse discards it
    tick(1'b1, W'(32), 1'b1);
    tick(1'b0, '0, 1'b1);
    rstn = 1'b0;
    #1;
    check("midreset_valid", 32'(valid_out), 32'd0);
    check("midreset_dout", 32'(dout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick(1'b0, '0, 1'b1);
    strobe(32, 1, "post_rst0");
    strobe(0, -3, "post_rst1");
    strobe(0, 3, "post_rst2");
    strobe(0, -1, "post_rst3");
    strobe(0, 0, "post_rst4");
    drain();

    // Output scaling boundaries
    apply_reset();
    strobe(16, rnd16[0], "imp16_0");
    for (int i = 1; i < 4; i++) strobe(0, rnd16[i], "imp16_n");
    drain();
    apply_reset();
    strobe('h0FFFF0, big[0], "impbig_0");
    for (int i = 1; i < 4; i++) strobe(0, big[i], "impbig_n");
    drain();
    apply_reset();
    strobe(-16, neg16[0], "impneg_0");
    for (int i = 1; i < 4; i++) strobe(0, neg16[i], "impneg_n");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_cic_comb

`default_nettype wire
